// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: state encoding for the sequential
// units and the default operand width.
package alu_pkg;

  // Default operand width used by the ALU datapath.
  localparam int DEFAULT_N = 8;

  // Sequential multiplier control states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Width of a step counter that must be able to hold the value n.
  function automatic int ct_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Request/response bundle for the sequential multiplier.
//
// Handshake: the requester raises start with sgn/a/b valid for one cycle;
// the request is taken only on an edge where busy=0 and done may be either
// value (the unit is idle). While busy=1, start is ignored. done pulses high
// for exactly one cycle with y valid; y then holds until the next product
// completes. busy and done are never high together.
interface seq_mul_if #(
  parameter int N = alu_pkg::DEFAULT_N
) ();

  logic             start;
  logic             sgn;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   y;
  alu_pkg::state_t  dbg_state;

  // Requester side (ALU decoder or bench).
  modport master (
    output start, sgn, a, b,
    input  busy, done, y, dbg_state
  );

  // Multiplier side.
  modport slave (
    input  start, sgn, a, b,
    output busy, done, y, dbg_state
  );

endinterface

// File: rtl/rca_add.sv
// Ripple-carry adder used for the multiplier's accumulate step.
module rca_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;

  // Carry ripples LSB to MSB; the final carry-out is not needed because the
  // product magnitude always fits in W bits.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < W - 1; i++) begin
      carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
    end
    sum = x ^ y ^ carry;
  end

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one partial product per clock on operand
// magnitudes, followed by a sign-correction cycle. Latency is N+1 clocks from
// the accept edge to the done pulse.
module seq_mul
  import alu_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic     clk,
  input  logic     rst,
  seq_mul_if.slave bus
);

  localparam int              W       = 2 * N;
  localparam int              IW      = $clog2(N);
  localparam int              CTW     = ct_width(N);
  localparam logic [CTW-1:0]  CT_LAST = CTW'(N - 1);
  localparam logic [CTW-1:0]  CT_ONE  = CTW'(1);
  localparam logic [N-1:0]    ONE_N   = N'(1);
  localparam logic [W-1:0]    ONE_W   = W'(1);

  state_t          state;
  logic [W-1:0]    acc;
  logic [CTW-1:0]  ct;
  logic [N-1:0]    mag_a;
  logic [N-1:0]    mag_b;
  logic            neg;
  logic            busy_r;
  logic            done_r;
  logic [W-1:0]    y_r;

  logic [N-1:0]    in_mag_a;
  logic [N-1:0]    in_mag_b;
  logic            in_neg;
  logic [IW-1:0]   ct_idx;
  logic [N-1:0]    pp_n;
  logic [W-1:0]    pp;
  logic [W-1:0]    sum;

  // Operand magnitudes and result sign for the capture cycle. The magnitude
  // of the most negative value wraps to 2^(N-1), which is correct unsigned.
  always_comb begin
    in_mag_a = (bus.sgn & bus.a[N-1]) ? (~bus.a + ONE_N) : bus.a;
    in_mag_b = (bus.sgn & bus.b[N-1]) ? (~bus.b + ONE_N) : bus.b;
    in_neg   = bus.sgn & (bus.a[N-1] ^ bus.b[N-1]);
  end

  // Partial product for the current multiplier bit, aligned by ct.
  always_comb begin
    ct_idx = ct[IW-1:0];
    pp_n   = mag_a & {N{mag_b[ct_idx]}};
    pp     = {{N{1'b0}}, pp_n} << ct;
  end

  rca_add #(
    .W (W)
  ) u_add (
    .x   (acc),
    .y   (pp),
    .cin (1'b0),
    .sum (sum)
  );

  // Control FSM with registered busy/done/y. ct ends at N after the last
  // RUN cycle, which is why it carries one extra bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      ct     <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      y_r    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            neg    <= in_neg;
            acc    <= '0;
            ct     <= '0;
            busy_r <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= sum;
          ct  <= ct + CT_ONE;
          if (ct == CT_LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          y_r    <= neg ? (~acc + ONE_W) : acc;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.y         = y_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: directed N=4 cases plus randomized N=8 traffic, both
// checked every cycle against a timeline model built on plain integer
// multiplication.
module tb_seq_mul;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mul_if #(.N(4)) bus4 ();
  seq_mul_if #(.N(8)) bus8 ();

  seq_mul #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  seq_mul #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed or unsigned n-bit product truncated to 2n bits.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic s, input int n);
    longint av, bv, p, mask;
    av = longint'(a);
    bv = longint'(b);
    if (s && a[n-1]) av = av - (longint'(1) << n);
    if (s && b[n-1]) bv = bv - (longint'(1) << n);
    p    = av * bv;
    mask = (longint'(1) << (2 * n)) - 1;
    return 16'(p & mask);
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [15:0] exp_q4[$];
  logic [15:0] exp_q[$];
  int          rem4 = 0, rem8 = 0;
  logic        m_busy4 = 0, m_done4 = 0, m_busy8 = 0, m_done8 = 0;
  logic [15:0] m_y4 = '0, m_y8 = '0;
  int          acc_cnt8 = 0;

  // Model for the N=4 unit: a request taken while idle completes N+1 edges later.
  always @(posedge clk) begin
    if (rst) begin
      rem4 = 0; m_busy4 = 0; m_done4 = 0; m_y4 = '0; exp_q4.delete();
    end else begin
      m_done4 = 0;
      if (rem4 > 0) begin
        rem4--;
        if (rem4 == 0) begin
          m_y4 = exp_q4.pop_front(); m_done4 = 1; m_busy4 = 0;
        end
      end else if (bus4.start === 1'b1) begin
        exp_q4.push_back(ref_mul({4'b0, bus4.a}, {4'b0, bus4.b}, bus4.sgn, 4));
        rem4 = 5; m_busy4 = 1;
      end
    end
  end

  // Model for the N=8 unit.
  always @(posedge clk) begin
    if (rst) begin
      rem8 = 0; m_busy8 = 0; m_done8 = 0; m_y8 = '0; exp_q.delete();
    end else begin
      m_done8 = 0;
      if (rem8 > 0) begin
        rem8--;
        if (rem8 == 0) begin
          m_y8 = exp_q.pop_front(); m_done8 = 1; m_busy8 = 0;
        end
      end else if (bus8.start === 1'b1) begin
        exp_q.push_back(ref_mul(bus8.a, bus8.b, bus8.sgn, 8));
        rem8 = 9; m_busy8 = 1; acc_cnt8++;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy4", 32'(bus4.busy), 32'(m_busy4));
      check("done4", 32'(bus4.done), 32'(m_done4));
      check("y4", 32'(bus4.y), 32'(m_y4[7:0]));
      check("excl4", 32'(bus4.busy & bus4.done), 32'd0);
      check("busy8", 32'(bus8.busy), 32'(m_busy8));
      check("done8", 32'(bus8.done), 32'(m_done8));
      check("y8", 32'(bus8.y), 32'(m_y8));
      check("excl8", 32'(bus8.busy & bus8.done), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic s);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.sgn = s; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.sgn = 1'($urandom);
  endtask

  // Called at the negedge right after the accept edge (k=0).
  task automatic wait_done4(output int k, output int bcnt);
    k = 0;
    bcnt = (bus4.busy === 1'b1) ? 1 : 0;
    while (bus4.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (bus4.busy === 1'b1) bcnt++;
    end
  endtask

  task automatic run4(input string name, input logic [3:0] a, input logic [3:0] b,
                      input logic s, input logic [7:0] exp_y);
    int k, bcnt;
    start4(a, b, s);
    wait_done4(k, bcnt);
    check({name, "_lat"}, 32'(k), 32'd5);
    check({name, "_busy_cycles"}, 32'(bcnt), 32'd5);
    check({name, "_y"}, 32'(bus4.y), 32'(exp_y));
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h00;
      3: return 8'h7F;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int k, bcnt, cyc, seen_done;
    bus4.start = 0; bus4.sgn = 0; bus4.a = '0; bus4.b = '0;
    bus8.start = 0; bus8.sgn = 0; bus8.a = '0; bus8.b = '0;

    // Hand-computed values pinning the reference model.
    check("pin_u_3x5", 32'(ref_mul(8'd3, 8'd5, 1'b0, 4)), 32'h0F);
    check("pin_s_m3x5", 32'(ref_mul(8'hD, 8'h5, 1'b1, 4)), 32'hF1);
    check("pin_s_m8xm8", 32'(ref_mul(8'h8, 8'h8, 1'b1, 4)), 32'h40);
    check("pin_s_m1xm1_8", 32'(ref_mul(8'hFF, 8'hFF, 1'b1, 8)), 32'h0001);
    check("pin_u_ffxff_8", 32'(ref_mul(8'hFF, 8'hFF, 1'b0, 8)), 32'hFE01);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy4", 32'(bus4.busy), 32'd0);
    check("rst_done4", 32'(bus4.done), 32'd0);
    check("rst_y4", 32'(bus4.y), 32'd0);
    check("rst_state4", 32'(bus4.dbg_state), 32'(ST_IDLE));
    check("rst_y8", 32'(bus8.y), 32'd0);
    chk_en = 1'b1;

    // Directed N=4 products.
    run4("u_3x5", 4'd3, 4'd5, 1'b0, 8'h0F);
    run4("s_m3x5", 4'hD, 4'h5, 1'b1, 8'hF1);
    run4("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
    run4("s_m8x7", 4'h8, 4'h7, 1'b1, 8'hC8);
    run4("u_fxf", 4'hF, 4'hF, 1'b0, 8'hE1);
    run4("s_fxf", 4'hF, 4'hF, 1'b1, 8'h01);

    // start during RUN is ignored; start in the done cycle is accepted.
    @(negedge clk);
    bus4.a = 4'd3; bus4.b = 4'd5; bus4.sgn = 1'b0; bus4.start = 1'b1;
    @(negedge clk); bus4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus4.a = 4'd1; bus4.b = 4'd1; bus4.start = 1'b1;
    @(negedge clk); bus4.start = 1'b0;
    k = 0;
    while (bus4.done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("ign_done_seen", 32'(bus4.done), 32'd1);
    check("ign_y", 32'(bus4.y), 32'h0F);
    bus4.a = 4'd2; bus4.b = 4'd2; bus4.sgn = 1'b0; bus4.start = 1'b1;
    @(negedge clk); bus4.start = 1'b0;
    check("b2b_hold_y", 32'(bus4.y), 32'h0F);
    check("b2b_busy", 32'(bus4.busy), 32'd1);
    wait_done4(k, bcnt);
    check("b2b_lat", 32'(k), 32'd5);
    check("b2b_y", 32'(bus4.y), 32'h04);

    // Reset in the middle of a product.
    @(negedge clk);
    bus4.a = 4'd7; bus4.b = 4'd3; bus4.sgn = 1'b0; bus4.start = 1'b1;
    @(negedge clk); bus4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus4.busy), 32'd0);
    check("mid_rst_done", 32'(bus4.done), 32'd0);
    check("mid_rst_y", 32'(bus4.y), 32'd0);
    seen_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus4.done === 1'b1) seen_done++;
    end
    check("mid_rst_no_done", 32'(seen_done), 32'd0);
    run4("post_rst_2x3", 4'd2, 4'd3, 1'b0, 8'h06);

    // Randomized N=8 traffic, including starts while busy and in done cycles.
    cyc = 0;
    while (acc_cnt8 < 1000 && cyc < 40000) begin
      @(negedge clk);
      bus8.start = ($urandom_range(0, 2) == 0);
      bus8.sgn   = 1'($urandom_range(0, 1));
      bus8.a     = pick8();
      bus8.b     = pick8();
      cyc++;
    end
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);
    check("rand_accepts", 32'(acc_cnt8 >= 1000), 32'd1);
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);
    check("rand_idle", 32'(bus8.busy), 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
